// File: rtl/call_scheduler_pkg.sv
// Shared types and constants for the elevator call scheduler.
package call_scheduler_pkg;

    localparam int NFLOORS_DEFAULT = 8;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN,
        ST_SERVE
    } state_t;

endpackage

// File: rtl/call_scheduler_call_mask.sv
// Combinational test for pending calls strictly above / strictly below the car.
module call_mask
    import call_scheduler_pkg::*;
#(
    parameter int NFLOORS = NFLOORS_DEFAULT
) (
    input  logic [NFLOORS-1:0] pend_any,
    input  logic [2:0]         floor,
    output logic               any_above,
    output logic               any_below
);

    logic [NFLOORS-1:0] above_mask;
    logic [NFLOORS-1:0] below_mask;

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < NFLOORS; i++) begin
            above_mask[i] = (i > int'(floor));
            below_mask[i] = (i < int'(floor));
        end
    end

    assign any_above = |(pend_any & above_mask);
    assign any_below = |(pend_any & below_mask);

endmodule

// File: rtl/call_scheduler.sv
// LOOK-style single-car call scheduler. Optional idle homing to floor 0
// is built only when the IDLE_HOME_EN macro is defined.
module call_scheduler
    import call_scheduler_pkg::*;
#(
    parameter int NFLOORS    = NFLOORS_DEFAULT,
    parameter int HOME_TICKS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] up_req,
    input  logic [NFLOORS-1:0] down_req,
    input  logic [NFLOORS-1:0] car_req,
    input  logic [2:0]         floor,
    input  logic               arrived,
    input  logic               door_done,
    input  logic               tick,
    output logic [1:0]         dir,
    output logic               move_cmd,
    output logic               open_cmd,
    output logic [NFLOORS-1:0] pend_up,
    output logic [NFLOORS-1:0] pend_down,
    output logic [NFLOORS-1:0] pend_car
);

    localparam logic [NFLOORS-1:0] TOP_OH = {1'b1, {(NFLOORS-1){1'b0}}};
    localparam logic [NFLOORS-1:0] BOT_OH = NFLOORS'(1);

    state_t             state;
    logic [NFLOORS-1:0] floor_oh;
    logic               any_above, any_below;
    logic               at_floor, stop_up, stop_down, home_set;
    logic [NFLOORS-1:0] clr_up, clr_down, clr_car;
    logic [NFLOORS-1:0] absorb_up, absorb_down, absorb_car;

    assign floor_oh = NFLOORS'(1) << floor;

    call_mask #(.NFLOORS(NFLOORS)) u_mask (
        .pend_any  (pend_up | pend_down | pend_car),
        .floor     (floor),
        .any_above (any_above),
        .any_below (any_below)
    );

    assign at_floor  = |((pend_up | pend_down | pend_car) & floor_oh);
    // A hall call against the travel direction only stops the car when it is the last call that way.
    assign stop_up   = |(pend_car & floor_oh) || |(pend_up & floor_oh) || (floor == 3'(NFLOORS-1))
                       || (|(pend_down & floor_oh) && !any_above);
    assign stop_down = |(pend_car & floor_oh) || |(pend_down & floor_oh) || (floor == 3'd0)
                       || (|(pend_up & floor_oh) && !any_below);

    always_comb begin
        clr_up      = '0;
        clr_down    = '0;
        clr_car     = '0;
        absorb_up   = '0;
        absorb_down = '0;
        absorb_car  = '0;
        case (state)
            ST_IDLE: if (at_floor) begin
                clr_up   = floor_oh;
                clr_down = floor_oh;
                clr_car  = floor_oh;
            end
            ST_UP: if (arrived && stop_up) begin
                clr_car = floor_oh;
                clr_up  = floor_oh;
                if (!any_above) clr_down = floor_oh;
            end
            ST_DOWN: if (arrived && stop_down) begin
                clr_car  = floor_oh;
                clr_down = floor_oh;
                if (!any_below) clr_up = floor_oh;
            end
            ST_SERVE: begin
                // With no travel direction (served straight from IDLE) both hall calls are absorbed.
                absorb_car = floor_oh;
                if (dir != DIR_DOWN) absorb_up   = floor_oh;
                if (dir != DIR_UP)   absorb_down = floor_oh;
            end
            default: ;
        endcase
    end

`ifdef IDLE_HOME_EN
    localparam int CNT_W = $clog2(HOME_TICKS + 1);
    logic [CNT_W-1:0] idle_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_IDLE || floor == 3'd0) begin
            idle_cnt <= '0;
        end else if (tick) begin
            if (idle_cnt == CNT_W'(HOME_TICKS - 1)) idle_cnt <= '0;
            else                                    idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign home_set = (state == ST_IDLE) && (floor != 3'd0) && tick
                      && (idle_cnt == CNT_W'(HOME_TICKS - 1));
`else
    assign home_set = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_up   <= '0;
            pend_down <= '0;
            pend_car  <= '0;
        end else begin
            pend_up   <= (pend_up   & ~clr_up)   | (up_req   & ~absorb_up   & ~TOP_OH);
            pend_down <= (pend_down & ~clr_down) | (down_req & ~absorb_down & ~BOT_OH);
            pend_car  <= (pend_car  & ~clr_car)  | (car_req  & ~absorb_car)
                         | (home_set ? BOT_OH : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            dir      <= DIR_IDLE;
            move_cmd <= 1'b0;
            open_cmd <= 1'b0;
        end else begin
            open_cmd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (at_floor) begin
                        state    <= ST_SERVE;
                        open_cmd <= 1'b1;
                    end else if (any_above) begin
                        state    <= ST_UP;
                        dir      <= DIR_UP;
                        move_cmd <= 1'b1;
                    end else if (any_below) begin
                        state    <= ST_DOWN;
                        dir      <= DIR_DOWN;
                        move_cmd <= 1'b1;
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (arrived && (state == ST_UP ? stop_up : stop_down)) begin
                        state    <= ST_SERVE;
                        move_cmd <= 1'b0;
                        open_cmd <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (door_done) begin
                        if (dir != DIR_DOWN && any_above) begin
                            state <= ST_UP;   dir <= DIR_UP;   move_cmd <= 1'b1;
                        end else if (any_below) begin
                            state <= ST_DOWN; dir <= DIR_DOWN; move_cmd <= 1'b1;
                        end else if (any_above) begin
                            state <= ST_UP;   dir <= DIR_UP;   move_cmd <= 1'b1;
                        end else begin
                            state <= ST_IDLE; dir <= DIR_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_call_scheduler.sv
// Directed bench for call_scheduler; define IDLE_HOME_EN to match a homing build.
module tb_call_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] up_req = '0, down_req = '0, car_req = '0;
    logic [2:0] floor = '0;
    logic       arrived = 1'b0, door_done = 1'b0, tick = 1'b0;
    logic [1:0] dir;
    logic       move_cmd, open_cmd;
    logic [7:0] pend_up, pend_down, pend_car;

    int total = 0;
    int bad   = 0;

    call_scheduler #(.NFLOORS(8), .HOME_TICKS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_req    (up_req),
        .down_req  (down_req),
        .car_req   (car_req),
        .floor     (floor),
        .arrived   (arrived),
        .door_done (door_done),
        .tick      (tick),
        .dir       (dir),
        .move_cmd  (move_cmd),
        .open_cmd  (open_cmd),
        .pend_up   (pend_up),
        .pend_down (pend_down),
        .pend_car  (pend_car)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic arrive(input logic [2:0] f);
        floor = f; arrived = 1'b1; step(); arrived = 1'b0;
    endtask

    task automatic finish_door();
        door_done = 1'b1; step(); door_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({dir, move_cmd, open_cmd} !== 4'b0000) begin bad++;
            $display("FAIL reset_ctrl: got dir=%b move=%b open=%b, want all 0", dir, move_cmd, open_cmd); end
        total++; if ({pend_up, pend_down, pend_car} !== 24'h0) begin bad++;
            $display("FAIL reset_pend: got %h %h %h, want 0", pend_up, pend_down, pend_car); end
    endtask

    task automatic test_travel_up();
        do_reset();
        floor = 3'd0; car_req = 8'h20; step(); car_req = '0;
        total++; if (pend_car !== 8'h20) begin bad++;
            $display("FAIL up_latch: got pend_car=%h, want 20", pend_car); end
        step();
        total++; if (dir !== 2'b01 || move_cmd !== 1'b1) begin bad++;
            $display("FAIL up_start: got dir=%b move=%b, want 01 1", dir, move_cmd); end
        for (int f = 1; f <= 4; f++) begin
            arrive(3'(f));
            total++; if (move_cmd !== 1'b1 || open_cmd !== 1'b0) begin bad++;
                $display("FAIL up_pass%0d: got move=%b open=%b, want 1 0", f, move_cmd, open_cmd); end
        end
        arrive(3'd5);
        total++; if (open_cmd !== 1'b1 || move_cmd !== 1'b0 || pend_car !== 8'h00) begin bad++;
            $display("FAIL up_stop: got open=%b move=%b pend_car=%h, want 1 0 00", open_cmd, move_cmd, pend_car); end
        step();
        total++; if (open_cmd !== 1'b0 || dir !== 2'b01) begin bad++;
            $display("FAIL up_open_width: got open=%b dir=%b, want 0 01", open_cmd, dir); end
        finish_door();
        total++; if (dir !== 2'b00 || move_cmd !== 1'b0) begin bad++;
            $display("FAIL up_to_idle: got dir=%b move=%b, want 00 0", dir, move_cmd); end
    endtask

    task automatic test_look();
        do_reset();
        floor = 3'd2; down_req = 8'h08; car_req = 8'h40; step(); down_req = '0; car_req = '0;
        step();
        arrive(3'd3);
        total++; if (move_cmd !== 1'b1 || open_cmd !== 1'b0 || pend_down !== 8'h08) begin bad++;
            $display("FAIL look_pass3: got move=%b open=%b pend_down=%h, want 1 0 08", move_cmd, open_cmd, pend_down); end
        arrive(3'd6);
        total++; if (open_cmd !== 1'b1 || pend_car !== 8'h00 || pend_down !== 8'h08) begin bad++;
            $display("FAIL look_stop6: got open=%b pend_car=%h pend_down=%h, want 1 00 08", open_cmd, pend_car, pend_down); end
        finish_door();
        total++; if (dir !== 2'b10 || move_cmd !== 1'b1) begin bad++;
            $display("FAIL look_reverse: got dir=%b move=%b, want 10 1", dir, move_cmd); end
        arrive(3'd5);
        total++; if (move_cmd !== 1'b1 || open_cmd !== 1'b0) begin bad++;
            $display("FAIL look_pass5: got move=%b open=%b, want 1 0", move_cmd, open_cmd); end
        arrive(3'd3);
        total++; if (open_cmd !== 1'b1 || pend_down !== 8'h00 || dir !== 2'b10) begin bad++;
            $display("FAIL look_stop3: got open=%b pend_down=%h dir=%b, want 1 00 10", open_cmd, pend_down, dir); end
        finish_door();
    endtask

    task automatic test_absorb();
        do_reset();
        floor = 3'd0; car_req = 8'h10; step(); car_req = '0;
        step();
        arrive(3'd4);
        car_req = 8'h10; up_req = 8'h10; down_req = 8'h10; step();
        car_req = '0; up_req = '0; down_req = '0;
        total++; if (pend_car !== 8'h00 || pend_up !== 8'h00 || pend_down !== 8'h10) begin bad++;
            $display("FAIL absorb: got car=%h up=%h down=%h, want 00 00 10", pend_car, pend_up, pend_down); end
        finish_door();
        total++; if (dir !== 2'b00 || move_cmd !== 1'b0) begin bad++;
            $display("FAIL absorb_idle: got dir=%b move=%b, want 00 0", dir, move_cmd); end
        step();
        total++; if (open_cmd !== 1'b1 || pend_down !== 8'h00) begin bad++;
            $display("FAIL absorb_reserve: got open=%b pend_down=%h, want 1 00", open_cmd, pend_down); end
        finish_door();
    endtask

    task automatic test_ignore();
        do_reset();
        floor = 3'd3; up_req = 8'h80; down_req = 8'h01; step(); up_req = '0; down_req = '0;
        total++; if (pend_up !== 8'h00 || pend_down !== 8'h00) begin bad++;
            $display("FAIL ignore_edges: got up=%h down=%h, want 00 00", pend_up, pend_down); end
        arrive(3'd3);
        door_done = 1'b1; step(); door_done = 1'b0;
        total++; if ({dir, move_cmd, open_cmd} !== 4'b0000) begin bad++;
            $display("FAIL ignore_idle_pulses: got dir=%b move=%b open=%b, want 00 0 0", dir, move_cmd, open_cmd); end
    endtask

    task automatic test_above_wins_and_reset();
        do_reset();
        floor = 3'd3; up_req = 8'h40; car_req = 8'h02; step(); up_req = '0; car_req = '0;
        total++; if (pend_up !== 8'h40 || pend_car !== 8'h02) begin bad++;
            $display("FAIL both_latch: got up=%h car=%h, want 40 02", pend_up, pend_car); end
        step();
        total++; if (dir !== 2'b01 || move_cmd !== 1'b1) begin bad++;
            $display("FAIL above_wins: got dir=%b move=%b, want 01 1", dir, move_cmd); end
        down_req = 8'h20; step(); down_req = '0;
        rst = 1'b1; step(); rst = 1'b0;
        total++; if ({dir, move_cmd, open_cmd} !== 4'b0000 || {pend_up, pend_down, pend_car} !== 24'h0) begin bad++;
            $display("FAIL mid_reset: got dir=%b move=%b open=%b pend=%h %h %h, want all 0",
                     dir, move_cmd, open_cmd, pend_up, pend_down, pend_car); end
        step();
        total++; if (dir !== 2'b00 || move_cmd !== 1'b0) begin bad++;
            $display("FAIL post_reset_idle: got dir=%b move=%b, want 00 0", dir, move_cmd); end
    endtask

    task automatic test_home();
        do_reset();
        floor = 3'd5;
        for (int i = 0; i < 15; i++) begin
            tick = 1'b1; step(); tick = 1'b0; step();
        end
        total++; if (pend_car !== 8'h00) begin bad++;
            $display("FAIL home_early: got pend_car=%h after 15 ticks, want 00", pend_car); end
        tick = 1'b1; step(); tick = 1'b0;
`ifdef IDLE_HOME_EN
        total++; if (pend_car !== 8'h01) begin bad++;
            $display("FAIL home_set: got pend_car=%h after 16 ticks, want 01", pend_car); end
        step();
        total++; if (dir !== 2'b10 || move_cmd !== 1'b1) begin bad++;
            $display("FAIL home_move: got dir=%b move=%b, want 10 1", dir, move_cmd); end
`else
        step(); step();
        total++; if (pend_car !== 8'h00 || dir !== 2'b00) begin bad++;
            $display("FAIL home_parked: got pend_car=%h dir=%b, want 00 00", pend_car, dir); end
`endif
    endtask

    initial begin
        test_reset();
        test_travel_up();
        test_look();
        test_absorb();
        test_ignore();
        test_above_wins_and_reset();
        test_home();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
